key_cmd_ctrl: RTL and testbench

Command sequencer between the 4-key debouncer and the 6-digit seven-segment driver. It takes the debounced key value and its one-cycle "stable" flag, decodes each press into an edit command, and keeps a 6-digit BCD value plus an edit cursor. Holding increment or decrement starts auto-repeat after a delay. It also produces a blink mask so the digit under the cursor flashes on the display.

---
 rtl/key_cmd_if.sv | 13 +
 rtl/key_cmd_ctrl.sv | 145 ++++++++++++++
 tb/tb_key_cmd_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/key_cmd_if.sv
// Key-to-display command bus: debounced key input in, BCD value, cursor and
// blink mask out.
interface key_cmd_if;
  logic [3:0]  keyvalue;
  logic        keyflag;
  logic [23:0] bcd_data;
  logic [2:0]  cursor;
  logic [5:0]  dig_en;
  logic        upd;

  modport master (output keyvalue, keyflag, input  bcd_data, cursor, dig_en, upd);
  modport slave  (input  keyvalue, keyflag, output bcd_data, cursor, dig_en, upd);
endinterface

// File: rtl/key_cmd_ctrl.sv
// Key command sequencer: turns debounced key presses into digit edits with
// cursor, hold-to-repeat for INC/DEC and a blinking cursor digit.

// Per-digit edit lane. inc/dec only affect the lane the cursor selects.
module key_cmd_digit (
  input  logic [3:0] d,
  input  logic       sel,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] q
);
  always_comb begin
    q = d;
    if (clr)
      q = 4'd0;
    else if (sel && inc)
      q = (d >= 4'd9) ? 4'd0 : d + 4'd1;
    else if (sel && dec)
      // Non-BCD contents behave as 9, so DEC lands on 8.
      q = (d == 4'd0) ? 4'd9 : ((d > 4'd9) ? 4'd8 : d - 4'd1);
  end
endmodule

module key_cmd_ctrl #(
  parameter int unsigned HOLD_CYC   = 25_000_000,
  parameter int unsigned REPEAT_CYC = 5_000_000,
  parameter int unsigned BLINK_CYC  = 12_500_000
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  key_cmd_if.slave kc
);
  localparam int unsigned NUM_DIG = 6;
  localparam logic [24:0] HOLD_LD  = 25'(HOLD_CYC - 1);
  localparam logic [24:0] REP_LD   = 25'(REPEAT_CYC - 1);
  localparam logic [24:0] BLINK_LD = 25'(BLINK_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t                     state_q, state_d;
  logic [24:0]                hold_cnt, rep_cnt, blink_cnt;
  logic                       blink_on, rpt_dec;
  logic [NUM_DIG-1:0][3:0]    digit_q, digit_d;
  logic [2:0]                 cursor_q, cursor_d;
  logic                       upd_q;
  logic [NUM_DIG-1:0]         dig_en;

  logic k_sel, k_inc, k_dec, k_clr, ev;
  logic hold_exp, rep_exp, do_inc, do_dec, act;

  // Any flagged pattern that is not a single-key press acts as a release.
  always_comb begin
    ev       = kc.keyflag;
    k_sel    = ev && (kc.keyvalue == 4'b1110);
    k_inc    = ev && (kc.keyvalue == 4'b1101);
    k_dec    = ev && (kc.keyvalue == 4'b1011);
    k_clr    = ev && (kc.keyvalue == 4'b0111);
    hold_exp = !ev && (state_q == HOLD)   && (hold_cnt == 25'd0);
    rep_exp  = !ev && (state_q == REPEAT) && (rep_cnt  == 25'd0);
    do_inc   = k_inc || ((hold_exp || rep_exp) && !rpt_dec);
    do_dec   = k_dec || ((hold_exp || rep_exp) &&  rpt_dec);
    act      = k_sel || k_clr || do_inc || do_dec;
  end

  always_comb begin
    state_d = state_q;
    if (ev)
      state_d = (k_inc || k_dec) ? HOLD : IDLE;
    else if (hold_exp)
      state_d = REPEAT;
  end

  always_comb begin
    cursor_d = cursor_q;
    if (k_clr)
      cursor_d = 3'd0;
    else if (k_sel)
      cursor_d = (cursor_q == 3'd5) ? 3'd0 : cursor_q + 3'd1;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_DIG; i++) begin : g_dig
      key_cmd_digit u_dig (
        .d   (digit_q[i]),
        .sel (cursor_q == 3'(i)),
        .inc (do_inc),
        .dec (do_dec),
        .clr (k_clr),
        .q   (digit_d[i])
      );
      assign dig_en[i] = !((cursor_q == 3'(i)) && !blink_on && (state_q == IDLE));
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      rpt_dec  <= 1'b0;
      digit_q  <= '0;
      cursor_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      cursor_q <= cursor_d;
      upd_q    <= act;
      if (ev) begin
        if (k_inc || k_dec) begin
          hold_cnt <= HOLD_LD;
          rpt_dec  <= k_dec;
        end
      end else if (state_q == HOLD) begin
        if (hold_cnt == 25'd0) rep_cnt  <= REP_LD;
        else                   hold_cnt <= hold_cnt - 25'd1;
      end else if (state_q == REPEAT) begin
        rep_cnt <= (rep_cnt == 25'd0) ? REP_LD : rep_cnt - 25'd1;
      end
    end
  end

  // Edits and held keys keep the cursor digit lit; blinking only runs in IDLE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (act || state_q != IDLE) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LD) begin
      blink_cnt <= '0;
      blink_on  <= !blink_on;
    end else begin
      blink_cnt <= blink_cnt + 25'd1;
    end
  end

  assign kc.bcd_data = digit_q;
  assign kc.cursor   = cursor_q;
  assign kc.dig_en   = dig_en;
  assign kc.upd      = upd_q;
endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed bench for key_cmd_ctrl with short hold/repeat/blink periods.
module tb_key_cmd_ctrl;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  key_cmd_if kc();

  key_cmd_ctrl #(.HOLD_CYC(8), .REPEAT_CYC(4), .BLINK_CYC(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .kc        (kc)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flag is sampled on the next rising edge; returns in the cycle the action shows.
  task automatic press(input logic [3:0] kv);
    @(negedge sys_clk);
    kc.keyvalue = kv;
    kc.keyflag  = 1'b1;
    @(negedge sys_clk);
    kc.keyflag  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    logic [23:0] exp_bcd;
    logic [5:0]  exp_en;
    kc.keyvalue = 4'b1111;
    kc.keyflag  = 1'b0;

    // 1: reset values, single INC, release
    idle(2);
    chk("rst_bcd", kc.bcd_data, 24'h0);
    chk("rst_cur", kc.cursor, 3'd0);
    chk("rst_en",  kc.dig_en, 6'h3f);
    chk("rst_upd", kc.upd, 1'b0);
    sys_rst_n = 1'b1;
    idle(1);
    chk("post_rst_en", kc.dig_en, 6'h3f);
    press(4'b1101);
    chk("inc1_bcd", kc.bcd_data, 24'h000001);
    chk("inc1_upd", kc.upd, 1'b1);
    idle(1);
    chk("inc1_upd_off", kc.upd, 1'b0);
    press(4'b1111);
    chk("rel_bcd", kc.bcd_data, 24'h000001);
    chk("rel_upd", kc.upd, 1'b0);
    idle(12);
    chk("rel_idle_bcd", kc.bcd_data, 24'h000001);

    // 2: CLR, cursor walk and wrap, INC at digit 5
    press(4'b0111);
    chk("clr_bcd", kc.bcd_data, 24'h0);
    chk("clr_upd", kc.upd, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      press(4'b1110);
      chk("sel_cur", kc.cursor, 32'(k));
    end
    press(4'b1101);
    chk("inc_d5", kc.bcd_data, 24'h100000);
    press(4'b1111);
    press(4'b1110);
    chk("sel_wrap", kc.cursor, 3'd0);

    // 3: DEC wrap 0->9, INC wrap 9->0 without carry; two-key pattern as release
    press(4'b1011);
    chk("dec_wrap", kc.bcd_data, 24'h100009);
    press(4'b1001);
    chk("multi_rel_upd", kc.upd, 1'b0);
    press(4'b1101);
    chk("inc_wrap", kc.bcd_data, 24'h100000);
    press(4'b1111);

    // 4: held INC auto-repeats at +9, +13, +17; release wins over expiry at +21
    press(4'b1101);
    chk("hold_c1", kc.bcd_data, 24'h100001);
    for (int k = 2; k <= 19; k++) begin
      idle(1);
      exp_bcd = 24'h100001 + 24'(k >= 9) + 24'(k >= 13) + 24'(k >= 17);
      chk($sformatf("hold_bcd_c%0d", k), kc.bcd_data, exp_bcd);
      if (k == 8 || k == 9 || k == 13 || k == 17)
        chk($sformatf("hold_upd_c%0d", k), kc.upd, 32'(k != 8));
    end
    press(4'b1111);
    chk("rpt_rel_bcd", kc.bcd_data, 24'h100004);
    chk("rpt_rel_upd", kc.upd, 1'b0);
    idle(12);
    chk("rpt_rel_idle", kc.bcd_data, 24'h100004);

    // 5: blink at cursor 2, INC forces all digits on
    press(4'b1110);
    press(4'b1110);
    chk("blink_cur", kc.cursor, 3'd2);
    chk("blink_c1", kc.dig_en, 6'h3f);
    for (int k = 2; k <= 12; k++) begin
      idle(1);
      exp_en = (((k - 1) / 4) % 2 == 1) ? 6'b111011 : 6'b111111;
      chk($sformatf("blink_c%0d", k), kc.dig_en, exp_en);
    end
    idle(4);
    chk("blink_off_pre", kc.dig_en, 6'b111011);
    press(4'b1101);
    chk("blink_force", kc.dig_en, 6'h3f);
    chk("blink_inc", kc.bcd_data, 24'h100104);
    press(4'b1111);

    // 6: CLR lands on the repeat expiry, then reset mid-HOLD
    press(4'b1101);
    chk("r6_c1", kc.bcd_data, 24'h100204);
    idle(8);
    chk("r6_c9", kc.bcd_data, 24'h100304);
    idle(2);
    press(4'b0111);
    chk("clr_exp_bcd", kc.bcd_data, 24'h0);
    chk("clr_exp_cur", kc.cursor, 3'd0);
    chk("clr_exp_upd", kc.upd, 1'b1);
    idle(12);
    chk("clr_exp_idle", kc.bcd_data, 24'h0);
    press(4'b1110);
    press(4'b1101);
    chk("r6_hold_bcd", kc.bcd_data, 24'h000010);
    idle(3);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("arst_bcd", kc.bcd_data, 24'h0);
    chk("arst_cur", kc.cursor, 3'd0);
    chk("arst_en",  kc.dig_en, 6'h3f);
    chk("arst_upd", kc.upd, 1'b0);
    idle(2);
    sys_rst_n = 1'b1;
    idle(15);
    chk("post_arst_bcd", kc.bcd_data, 24'h0);
    chk("post_arst_cur", kc.cursor, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
